// File: rtl/sort_result_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sort_result_drain                                             |
// | Purpose  : Reads entries 0..len-1 of the sort result buffer in address   |
// |            order and streams them out on a valid/ready interface. The    |
// |            drain stops at the first entry whose index valid flag (MSB)   |
// |            is clear. A 2-entry skid FIFO absorbs the buffer's 1-cycle    |
// |            read latency so backpressure never drops data.                |
// | Ports    : CLK, RESET (sync, active-low)                                 |
// |            start/len           - drain request                           |
// |            buf_cen/wen/retn/a  - buffer read port (active-low enables)   |
// |            buf_q/buf_index     - buffer read data, 1 cycle after issue   |
// |            out_valid/ready/data/index/last - result stream               |
// |            busy/done/count_o   - drain status                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sort_result_drain #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  output logic              buf_cen,
  output logic              buf_wen,
  output logic              buf_retn,
  output logic [ADDR_W-1:0] buf_a,
  input  logic [DATA_W-1:0] buf_q,
  input  logic [IDX_W-1:0]  buf_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-2:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] C_DEPTH = ADDR_W'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        occ_q, occ_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;

  logic [DATA_W-1:0] fifo_data_q [2];
  logic [IDX_W-2:0]  fifo_idx_q  [2];
  logic              fifo_last_q [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic       cap_last;
  logic [2:0] slots_used;

  assign pop      = out_valid & out_ready;
  assign cap_last = (infl_addr_q == (len_q - ADDR_W'(1)));
  // FIFO slots committed after this cycle's pop: stored entries plus the
  // read whose data lands at the next edge.
  assign slots_used = 3'(occ_q) + 3'(infl_q) - 3'(pop);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    count_d     = count_q;
    issue       = 1'b0;
    push        = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    if (pop) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
          addr_d  = '0;
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            len_d   = (len > C_DEPTH) ? C_DEPTH : len;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        busy  = 1'b1;
        issue = (addr_q < len_q) && (slots_used < 3'd2);
        if (infl_q) begin
          if (buf_index[IDX_W-1]) begin
            push = 1'b1;
            if (cap_last) begin
              state_d = S_FLUSH;
            end
          end else begin
            // Unwritten entry: end of valid results. A read issued this
            // same cycle is still discarded in FLUSH.
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        if ((occ_q == 2'd0) && !infl_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      addr_d = addr_q + ADDR_W'(1);
    end
    infl_d      = issue;
    infl_addr_d = issue ? addr_q : infl_addr_q;
    occ_d       = occ_q + 2'(push) - 2'(pop);
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      count_q     <= '0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      count_q     <= count_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= buf_q;
      fifo_idx_q[wr_ptr_q]  <= buf_index[IDX_W-2:0];
      fifo_last_q[wr_ptr_q] <= cap_last;
    end
  end

  assign buf_cen   = ~issue;
  assign buf_wen   = 1'b1;
  assign buf_retn  = 1'b1;
  assign buf_a     = issue ? addr_q : '0;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_index = fifo_idx_q[rd_ptr_q];
  assign out_last  = out_valid & fifo_last_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule
`default_nettype wire
